// File: rtl/pattern_gen.sv
// pattern_gen: registered RGB test-pattern source on the pixel clock.
// Optional scrolling frame counter: define PATTERN_GEN_SCROLL_EN.
module pattern_gen #(
  parameter int unsigned COLOR_W     = 8,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned STRIPE_LOG2 = 3,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned FRAME_W     = 8,
  parameter bit          VSYNC_POL   = 1'b0
) (
  input  logic                   clkp,
  input  logic                   rst_n,
  input  logic [COORD_W-1:0]     px,
  input  logic [COORD_W-1:0]     py,
  input  logic                   de,
  input  logic                   vsync,
  input  logic [2:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic [FRAME_W-1:0]     frame
);

  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

  logic               vsync_q;
  logic               vsync_d;
  logic [2:0]         mode_q;
  logic [2:0]         mode_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               boundary;
  logic [COORD_W-1:0] xo;
  logic [COORD_W-1:0] sx;
  logic [2:0]         bar_idx;
  logic [31:0]        px_x8;
  logic               active;

  // Frame boundary: vsync just entered its active level.
  always_comb begin
    boundary = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    vsync_d  = vsync;
    mode_d   = boundary ? mode : mode_q;
  end

`ifdef PATTERN_GEN_SCROLL_EN
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;

  // Frame counter advances once per boundary, wrapping naturally.
  always_comb begin
    frame_d = boundary ? frame_q + FRAME_W'(1) : frame_q;
  end

  // Frame counter register.
  always_ff @(posedge clkp or negedge rst_n) begin
    if (!rst_n) frame_q <= '0;
    else        frame_q <= frame_d;
  end

  if (FRAME_W >= COORD_W) begin : g_xo_trunc
    assign xo = frame_q[COORD_W-1:0];
  end else begin : g_xo_ext
    assign xo = {{(COORD_W-FRAME_W){1'b0}}, frame_q};
  end

  assign frame = frame_q;
`else
  assign xo    = '0;
  assign frame = '0;
`endif

  // Scrolled x, bar index and active-area qualifier.
  always_comb begin
    sx      = px + xo;
    px_x8   = 32'(px) << 3;
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (px_x8 >= k * H_ACTIVE) bar_idx = bar_idx + 3'd1;
    end
    active = de && (32'(px) < H_ACTIVE) && (32'(py) < V_ACTIVE);
  end

  // Pattern select; blanking overrides every mode.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      case (mode_q)
        3'd0: begin
          r_d = py[COLOR_W-1:0];
          g_d = sx[COLOR_W-1:0];
          b_d = sx[STRIPE_LOG2] ? '0 : FULL;
        end
        3'd1: begin
          r_d = {COLOR_W{~bar_idx[1]}};
          g_d = {COLOR_W{~bar_idx[2]}};
          b_d = {COLOR_W{~bar_idx[0]}};
        end
        3'd2: begin
          r_d = (sx[CHECK_LOG2] ^ py[CHECK_LOG2]) ? '0 : FULL;
          g_d = r_d;
          b_d = r_d;
        end
        3'd3: begin
          r_d = solid[3*COLOR_W-1:2*COLOR_W];
          g_d = solid[2*COLOR_W-1:COLOR_W];
          b_d = solid[COLOR_W-1:0];
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
    end
  end

  // Pixel, mode and vsync history registers.
  always_ff @(posedge clkp or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= ~VSYNC_POL;
      mode_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      vsync_q <= vsync_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised video test-pattern source for the DVI path. Sits on the pixel clock between the VGA timing driver and `vga2tmds`. Turns the driver's pixel coordinates into registered RGB for one of several selectable patterns. Mode changes take effect only on frame boundaries, and patterns can optionally scroll with a frame counter.

## Interface

Parameters:
- `COLOR_W`, 8: bits per colour component; must be ≤ `COORD_W`
- `COORD_W`, 10: width of `px`/`py`
- `H_ACTIVE`, 640: active pixels per line
- `V_ACTIVE`, 480: active lines per frame
- `STRIPE_LOG2`, 3: log2 of blue stripe width in gradient mode
- `CHECK_LOG2`, 5: log2 of checker square size
- `FRAME_W`, 8: frame counter width
- `VSYNC_POL`, 0: active level of `vsync` (0 = active-low)

Ports:
- `clkp` in 1: pixel clock; the block's only clock
- `rst_n` in 1: asynchronous, active-low reset
- `px` in `COORD_W`: current pixel x, from the VGA driver
- `py` in `COORD_W`: current pixel y
- `de` in 1: active-video flag
- `vsync` in 1: vertical sync, polarity per `VSYNC_POL`
- `mode` in 3: requested pattern; sampled only at a frame boundary
- `solid` in `3*COLOR_W`: solid colour {R,G,B} for mode 3
- `r` out `COLOR_W`: red, registered
- `g` out `COLOR_W`: green, registered
- `b` out `COLOR_W`: blue, registered
- `frame` out `FRAME_W`: frame counter; constant 0 when scroll is compiled out

## Operation

- Frame boundary is one cycle where `vsync` is at its active level and `vsync_q` (the registered previous `vsync`) is not.
- `vsync_q` resets to the inactive level. If `vsync` is already active when reset releases, the first clock counts as a boundary.
- At a boundary:
  - `mode_q <= mode`. A `mode` change in the boundary cycle itself is taken.
  - `frame <= frame + 1`, wrapping from 2^`FRAME_W`-1 to 0.
- `mode_q` resets to 0. After reset the gradient pattern runs until the first boundary.
- Scroll offset `xo` = `frame` zero-extended or truncated to `COORD_W` (0 without scroll). Define `sx` = (`px` + `xo`) mod 2^`COORD_W`.
- Patterns, by `mode_q`:
  - 0, gradient:
    - r = `py[COLOR_W-1:0]`
    - g = `sx[COLOR_W-1:0]`
    - b = all-ones when `sx[STRIPE_LOG2]`=0, else 0
  - 1, colour bars:
    - idx = min(7, floor(`px`*8/`H_ACTIVE`))
    - r = ~idx[1], g = ~idx[2], b = ~idx[0], each replicated to full scale
    - Order left to right: white, yellow, cyan, green, magenta, red, blue, black
  - 2, checker: white when `sx[CHECK_LOG2]` XOR `py[CHECK_LOG2]` = 0, else black.
  - 3, solid: r,g,b = `solid[3C-1:2C]`, `solid[2C-1:C]`, `solid[C-1:0]`, where C = `COLOR_W`.
  - 4–7: black.
- When `de`=0, or `px` ≥ `H_ACTIVE`, or `py` ≥ `V_ACTIVE`, outputs are 0 regardless of mode.
- `solid` is not latched; changes appear on the next pixel.

## Timing

- Reset (async assert, sync release to `clkp`): `r`=`g`=`b`=0, `frame`=0, `mode_q`=0, `vsync_q` inactive.
- Latency: exactly 1 `clkp` cycle from `px`/`py`/`de`/`solid` to `r`/`g`/`b`. The integrator offsets the driver's coordinates by one pixel.
- Mode/frame update: the boundary cycle's inputs use the old `mode_q`/`frame`. The new values apply from the next cycle.
- No handshake. Every input is consumed every cycle, and there are no stalls.
- Reset mid-frame: outputs are forced to 0 immediately. Pattern generation resumes in mode 0 on the first post-release cycle.

## Configuration

- `PATTERN_GEN_SCROLL_EN` defined:
  - Frame counter is implemented.
  - `xo` = `frame`, so modes 0 and 2 scroll right-to-left by 1 pixel per frame.
  - `frame` output counts.
- Not defined:
  - Counter logic is omitted.
  - `frame` is tied to 0 and `xo` = 0; all patterns are static.
  - Mode latching at boundaries is unchanged.

## Test plan

- Reset with `de`=1 and `px`=5 -> `r`/`g`/`b`=0 while `rst_n`=0. First post-release pixel, mode 0, `px`=5, `py`=3 -> `r`=3, `g`=5, `b`=FF one cycle later.
- Mode 1, `H_ACTIVE`=640, sweep `px` 0..639 -> bar changes at `px`=80,160,…,560. `px`=0 → FFFFFF; `px`=100 → FFFF00; `px`=639 → 000000.
- `mode` set to 2 mid-frame -> pattern unchanged until the vsync active edge. Next cycle: checker, `px`=32,`py`=0 → black; `px`=32,`py`=32 → white.
- Mode 3, `solid`=0x123456, toggle `de` -> `r`/`g`/`b`=12/34/56 when `de`=1 and 0 when `de`=0, each one cycle later.
- With `PATTERN_GEN_SCROLL_EN`, mode 0, apply 257 vsync edges -> `frame` wraps 255→0 then reads 1. At `px`=0, `g` equals `frame`. Without the macro, `frame` stays 0.
- Mode 5, and `py`=V_ACTIVE with `de` forced high -> all outputs 0.
